// File: rtl/rle_block_expander.sv
// Expands a run-length block descriptor into 64 zig-zag ordered coefficients,
// one per beat under valid/ready backpressure, flagging inconsistent descriptors.
module rle_block_expander (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_flag,
  input  logic [5:0]   in_left,
  input  logic [5:0]   in_right,
  input  logic [5:0]   in_size,
  input  logic [895:0] in_array,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_coef,
  output logic [5:0]   out_index,
  output logic         out_last,
  output logic         err
);

  localparam int unsigned ENT_W = 14;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned RUN_W = ENT_W - VAL_W;
  localparam int unsigned NCOEF = 64;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned ARR_W = ENT_W * NCOEF;
  localparam int unsigned OFF_W = 10;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOEF - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_RUN,
    ST_VAL,
    ST_TAIL
  } state_e;

  state_e             st_q, st_d, st_r;
  logic [IDX_W-1:0]   cnt_q, cnt_d, cnt_r;
  logic [IDX_W-1:0]   p_q, p_d, p_r;
  logic               tail_err_q, tail_err_d, tail_r;
  logic [ARR_W-1:0]   arr_q, arr_d;
  logic [IDX_W-1:0]   right_q, right_d;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [VAL_W-1:0]   out_coef_q, out_coef_d;
  logic [IDX_W-1:0]   out_index_q, out_index_d;
  logic               out_last_q, out_last_d;
  logic               err_q, err_d;

  logic               accept;
  logic               gen;
  logic               load;
  logic [ARR_W-1:0]   arr_src;
  logic [IDX_W-1:0]   right_src;
  logic [IDX_W-1:0]   idx_r;
  logic [OFF_W-1:0]   off_p, off_n;
  logic [VAL_W-1:0]   val_p;
  logic [RUN_W-1:0]   run_p, run_n;
  logic               mismatch;
  logic               overrun;

  assign accept    = in_valid && in_ready_q;
  assign gen       = (st_q != ST_IDLE) && (!out_valid_q || out_ready);
  assign load      = accept || gen;

  // On acceptance the first beat is computed straight from the input descriptor.
  assign arr_src   = accept ? in_array : arr_q;
  assign right_src = accept ? in_right : right_q;
  assign p_r       = accept ? (in_size - IDX_W'(1)) : p_q;
  assign tail_r    = accept ? 1'b0 : tail_err_q;
  assign idx_r     = accept ? '0 : (out_index_q + IDX_W'(1));

  assign off_p     = OFF_W'(p_r) * OFF_W'(ENT_W);
  assign off_n     = OFF_W'(p_r - IDX_W'(1)) * OFF_W'(ENT_W);
  assign val_p     = arr_src[off_p +: VAL_W];
  assign run_p     = arr_src[off_p + OFF_W'(VAL_W) +: RUN_W];
  assign run_n     = arr_src[off_n + OFF_W'(VAL_W) +: RUN_W];

  assign mismatch  = (LAST_IDX - idx_r) != right_src;
  assign overrun   = !((st_r == ST_TAIL) || ((st_r == ST_VAL) && (p_r == '0)))
                   || ((st_r == ST_VAL) && (p_r == '0) && mismatch);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      tail_err_q  <= 1'b0;
      arr_q       <= '0;
      right_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      tail_err_q  <= tail_err_d;
      arr_q       <= arr_d;
      right_q     <= right_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  // Effective state for the beat being produced; a zero-run RUN collapses into VAL.
  always_comb begin
    st_r  = st_q;
    cnt_r = cnt_q;
    if (accept) begin
      if (!in_flag) begin
        st_r  = ST_TAIL;
        cnt_r = '0;
      end else if (in_left != '0) begin
        st_r  = ST_LEAD;
        cnt_r = in_left;
      end else if (run_p != '0) begin
        st_r  = ST_RUN;
        cnt_r = run_p;
      end else begin
        st_r  = ST_VAL;
        cnt_r = '0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    tail_err_d = tail_err_q;
    arr_d      = arr_q;
    right_d    = right_q;
    if (accept) begin
      arr_d   = in_array;
      right_d = in_right;
    end
    if (load) begin
      st_d       = st_r;
      cnt_d      = cnt_r;
      p_d        = p_r;
      tail_err_d = tail_r;
      unique case (st_r)
        ST_LEAD: begin
          if (cnt_r == IDX_W'(1)) begin
            st_d  = (run_p != '0) ? ST_RUN : ST_VAL;
            cnt_d = run_p;
          end else begin
            cnt_d = cnt_r - IDX_W'(1);
          end
        end
        ST_RUN: begin
          if (cnt_r == IDX_W'(1)) st_d = ST_VAL;
          cnt_d = cnt_r - IDX_W'(1);
        end
        ST_VAL: begin
          if (p_r == '0) begin
            st_d       = ST_TAIL;
            tail_err_d = mismatch;
          end else begin
            p_d   = p_r - IDX_W'(1);
            st_d  = (run_n != '0) ? ST_RUN : ST_VAL;
            cnt_d = run_n;
          end
        end
        default: ;
      endcase
      if (idx_r == LAST_IDX) st_d = ST_IDLE;
    end
  end

  // Output logic
  always_comb begin
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_coef_d  = out_coef_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    if (accept) in_ready_d = 1'b0;
    if (out_valid_q && out_ready && out_last_q) in_ready_d = 1'b1;
    if (load) begin
      out_valid_d = 1'b1;
      out_coef_d  = (st_r == ST_VAL) ? val_p : '0;
      out_index_d = idx_r;
      out_last_d  = (idx_r == LAST_IDX);
      err_d       = (accept ? 1'b0 : err_q)
                  | ((st_r == ST_TAIL) && tail_r)
                  | ((idx_r == LAST_IDX) && overrun);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rle_block_expander.sv
// Scoreboard bench for rle_block_expander: expected beats are queued when a
// descriptor is driven and compared against the collected output stream.
module tb_rle_block_expander;

  typedef struct packed {
    logic [7:0] coef;
    logic [5:0] idx;
    logic       last;
    logic       err;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_flag = 1'b0;
  logic [5:0]   in_left = '0;
  logic [5:0]   in_right = '0;
  logic [5:0]   in_size = '0;
  logic [895:0] in_array = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_coef;
  logic [5:0]   out_index;
  logic         out_last;
  logic         err;

  int tests_run = 0;
  int tests_failed = 0;

  beat_t exp_q[$];
  beat_t obs_q[$];
  logic  first_valid;
  logic  post_ready;
  logic  timed_out;
  int    stab_viol;
  int    rdy_viol;

  rle_block_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flag   (in_flag),
    .in_left   (in_left),
    .in_right  (in_right),
    .in_size   (in_size),
    .in_array  (in_array),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_index (out_index),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input beat_t b);
    return $sformatf("coef=%h idx=%0d last=%b err=%b", b.coef, b.idx, b.last, b.err);
  endfunction

  function automatic logic [895:0] set_ent(input logic [895:0] a, input int i,
                                           input logic [5:0] run, input logic [7:0] val);
    logic [895:0] r;
    r = a;
    r[i*14 +: 14] = {run, val};
    return r;
  endfunction

  // Drives one descriptor and collects every consumed beat into obs_q.
  task automatic run_block(input logic flag, input logic [5:0] left, input logic [5:0] right,
                           input logic [5:0] size, input logic [895:0] arr,
                           input logic [3:0] rpat);
    int    c;
    int    w;
    logic  done;
    logic  prev_stall;
    beat_t prev;
    beat_t cur;
    obs_q.delete();
    stab_viol = 0;
    rdy_viol = 0;
    timed_out = 1'b0;
    first_valid = 1'b0;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) timed_out = 1'b1;
    in_flag = flag; in_left = left; in_right = right; in_size = size; in_array = arr;
    in_valid = 1'b1;
    out_ready = rpat[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0; done = 1'b0; prev_stall = 1'b0; prev = '0;
    while (!done && c < 400) begin
      @(negedge clk);
      cur = {out_coef, out_index, out_last, err};
      if (c == 0) first_valid = out_valid;
      if (prev_stall && cur != prev) stab_viol++;
      if (in_ready) rdy_viol++;
      if (out_valid && out_ready) begin
        obs_q.push_back(cur);
        if (out_last) done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev = cur;
      @(posedge clk); #1;
      c++;
      out_ready = rpat[c % 4];
    end
    if (!done) timed_out = 1'b1;
    post_ready = in_ready;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests_run++;
    if ({in_ready, out_valid, out_coef, out_index, out_last, err} !== {1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: got rdy=%b vld=%b coef=%h idx=%0d last=%b err=%b, want rdy=1 vld=0 rest 0",
               in_ready, out_valid, out_coef, out_index, out_last, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_block;
    logic [895:0] arr;
    beat_t e, o;
    for (int i = 0; i < 28; i++) arr[i*32 +: 32] = $urandom;
    for (int n = 0; n < 64; n++) exp_q.push_back({8'h00, 6'(n), n == 63, 1'b0});
    run_block(1'b0, 6'd9, 6'd3, 6'd5, arr, 4'b1111);
    tests_run++;
    if (first_valid !== 1'b1) begin
      tests_failed++; $display("FAIL zero_latency: out_valid=%b one cycle after accept, want 1", first_valid);
    end
    tests_run++;
    if (obs_q.size() != 64 || timed_out) begin
      tests_failed++; $display("FAIL zero_count: got %0d beats (timeout=%b), want 64", obs_q.size(), timed_out);
    end
    tests_run++;
    if (post_ready !== 1'b1) begin
      tests_failed++; $display("FAIL zero_ready_after: in_ready=%b, want 1", post_ready);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL zero_beat: got %s, want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete();
  endtask

  task automatic sparse_exp(input int err_from);
    logic [7:0] v;
    for (int n = 0; n < 64; n++) begin
      v = (n == 2) ? 8'h05 : (n == 6) ? 8'hFF : 8'h00;
      exp_q.push_back({v, 6'(n), n == 63, n >= err_from});
    end
  endtask

  task automatic test_sparse;
    logic [895:0] arr;
    beat_t e, o;
    arr = '0;
    arr = set_ent(arr, 1, 6'd0, 8'h05);
    arr = set_ent(arr, 0, 6'd3, 8'hFF);
    sparse_exp(99);
    run_block(1'b1, 6'd2, 6'd57, 6'd2, arr, 4'b1111);
    tests_run++;
    if (obs_q.size() != 64 || timed_out) begin
      tests_failed++; $display("FAIL sparse_count: got %0d beats (timeout=%b), want 64", obs_q.size(), timed_out);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL sparse_beat: got %s, want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_full_wrap;
    logic [895:0] arr;
    beat_t e, o;
    arr = '0;
    for (int i = 0; i < 64; i++) arr = set_ent(arr, i, 6'd0, 8'(i));
    for (int n = 0; n < 64; n++) exp_q.push_back({8'(63 - n), 6'(n), n == 63, 1'b0});
    run_block(1'b1, 6'd0, 6'd0, 6'd0, arr, 4'b1111);
    tests_run++;
    if (obs_q.size() != 64 || timed_out) begin
      tests_failed++; $display("FAIL wrap_count: got %0d beats (timeout=%b), want 64", obs_q.size(), timed_out);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL wrap_beat: got %s, want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    logic [895:0] arr;
    beat_t e, o;
    arr = '0;
    arr = set_ent(arr, 1, 6'd0, 8'h05);
    arr = set_ent(arr, 0, 6'd3, 8'hFF);
    sparse_exp(99);
    run_block(1'b1, 6'd2, 6'd57, 6'd2, arr, 4'b1001);
    tests_run++;
    if (stab_viol != 0) begin
      tests_failed++; $display("FAIL bp_stable: %0d stalled cycles changed outputs, want 0", stab_viol);
    end
    tests_run++;
    if (rdy_viol != 0 || post_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_in_ready: %0d cycles ready mid-block, ready after=%b, want 0 and 1", rdy_viol, post_ready);
    end
    tests_run++;
    if (obs_q.size() != 64 || timed_out) begin
      tests_failed++; $display("FAIL bp_count: got %0d beats (timeout=%b), want 64", obs_q.size(), timed_out);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL bp_beat: got %s, want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_inconsistent;
    logic [895:0] arr;
    beat_t e, o;
    arr = '0;
    arr = set_ent(arr, 1, 6'd0, 8'h05);
    arr = set_ent(arr, 0, 6'd3, 8'hFF);
    sparse_exp(7);
    run_block(1'b1, 6'd2, 6'd10, 6'd2, arr, 4'b1111);
    tests_run++;
    if (obs_q.size() != 64 || timed_out) begin
      tests_failed++; $display("FAIL incons_count: got %0d beats (timeout=%b), want 64", obs_q.size(), timed_out);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL incons_beat: got %s, want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete();
    // A consistent follow-up block must start with err cleared.
    sparse_exp(99);
    run_block(1'b1, 6'd2, 6'd57, 6'd2, arr, 4'b1111);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL err_clear_beat: got %s, want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_overrun;
    logic [895:0] arr;
    logic [7:0]   v;
    beat_t e, o;
    arr = '0;
    arr = set_ent(arr, 2, 6'd0, 8'h11);
    arr = set_ent(arr, 1, 6'd0, 8'h22);
    arr = set_ent(arr, 0, 6'd0, 8'h33);
    for (int n = 0; n < 64; n++) begin
      v = (n == 62) ? 8'h11 : (n == 63) ? 8'h22 : 8'h00;
      exp_q.push_back({v, 6'(n), n == 63, n == 63});
    end
    run_block(1'b1, 6'd62, 6'd0, 6'd3, arr, 4'b1111);
    tests_run++;
    if (obs_q.size() != 64 || timed_out) begin
      tests_failed++; $display("FAIL overrun_count: got %0d beats (timeout=%b), want 64", obs_q.size(), timed_out);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL overrun_beat: got %s, want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_block;
    logic [895:0] arr;
    beat_t e, o;
    int    w;
    arr = '0;
    for (int i = 0; i < 64; i++) arr = set_ent(arr, i, 6'd0, 8'(i));
    @(posedge clk); #1;
    in_flag = 1'b1; in_left = '0; in_right = '0; in_size = '0; in_array = arr;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!(out_valid && out_index == 6'd30) && w < 100) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (!(out_valid && out_index == 6'd30)) begin
      tests_failed++; $display("FAIL midrst_reach: index 30 not seen within bound, idx=%0d", out_index);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_valid: out_valid=%b during reset, want 0", out_valid);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_release: in_ready=%b out_valid=%b, want 1 and 0", in_ready, out_valid);
    end
    for (int n = 0; n < 64; n++) exp_q.push_back({8'(63 - n), 6'(n), n == 63, 1'b0});
    run_block(1'b1, 6'd0, 6'd0, 6'd0, arr, 4'b1111);
    tests_run++;
    if (obs_q.size() != 64 || timed_out) begin
      tests_failed++; $display("FAIL midrst_count: got %0d beats (timeout=%b), want 64", obs_q.size(), timed_out);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL midrst_beat: got %s, want %s", fmt(o), fmt(e));
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_sparse();
    test_full_wrap();
    test_backpressure();
    test_inconsistent();
    test_overrun();
    test_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
